div_clock_arbiter: RTL
======================

Name: div_clock_arbiter

Overview:
- Shares one variable clock divider (ratio input, active-high async reset, toggling output clock) among NUM_REQ requesters.
- Each requester asks for a divide ratio. The block arbitrates round-robin and programs the divider's ratio. It then resets the divider, waits for SETTLE_EDGES output toggles, and signals Ready to the owner until the owner releases.
- Sits between clients and the divider instance, in the same clock domain as the divider.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BW_COUNT, 5, width of divide-ratio word; matches the divider's counter width.
- SETTLE_EDGES, 2, divider output toggles to observe before Ready (1..15).

Ports:
- Clock  in  1  system clock; also clocks the divider.
- ResetN  in  1  asynchronous, active-low reset.
- Req  in  NUM_REQ  per-requester request; held high for the whole ownership.
- ReqRatio  in  NUM_REQ*BW_COUNT  requester i's ratio at bits [i*BW_COUNT +: BW_COUNT].
- Grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- Ready  out  1  divider settled; owner may use the divided clock.
- DivResetVal  out  BW_COUNT  ratio driven to the divider.
- DivReset  out  1  active-high reset pulse to the divider.
- DivOutClock  in  1  divider output, sampled on Clock.

Behaviour:
- Reset (ResetN low, async):
  - State=IDLE; Grant=0, Ready=0, DivReset=1, DivResetVal=0.
  - Round-robin pointer=0, toggle counter=0, DivOutClock history register=0.
  - DivReset stays asserted during reset, so the divider is held in reset too.
- All outputs are registered.
- IDLE:
  - DivReset=0 (after the first clock following reset release); DivResetVal holds its last value.
  - If any Req is high, select the first requester at or above the pointer, wrapping modulo NUM_REQ.
  - Next cycle: Grant=onehot(sel), DivResetVal=ReqRatio[sel] (latched), DivReset=1, state=LOAD.
- LOAD (exactly 1 cycle):
  - DivReset=1; history register cleared to 0, matching the divider's post-reset output.
  - Toggle counter=0. Next state SETTLE, with DivReset=0.
- SETTLE:
  - A toggle is counted each cycle where DivOutClock != history; history updates every cycle.
  - When the count reaches SETTLE_EDGES: Ready=1 on the next edge, state=OWNED.
- OWNED:
  - Grant and Ready held. Changes on ReqRatio[owner] are ignored; the ratio stays latched.
  - Other requests wait.
- Release:
  - Req[owner] low in SETTLE or OWNED means on the next edge Grant=0, Ready=0, state=IDLE.
  - The pointer advances to (owner+1) mod NUM_REQ.
  - The divider is not reset on release; it keeps running at the last ratio.
- Request timing:
  - Minimum grant latency from IDLE is 1 cycle. Ready latency is at least 2 + SETTLE_EDGES*(ratio+1) cycles, with ratio 0 counting as a period of 1.
- Simultaneous events:
  - Multiple Req in IDLE: round-robin decides.
  - Owner release and another Req in the same cycle: the block passes through IDLE for 1 cycle, then grants using the updated pointer (no back-to-back grant).
- Non-owner Req dropping: no effect.
- ResetN asserted mid-operation: immediate return to the reset values above, including aborting SETTLE.
- Ratio 0 is legal; the divider toggles every cycle (divide by 2).
- Grant is always one-hot or zero; Ready implies Grant != 0.

Test Plan:
1. Release reset, then Req=0001, ReqRatio[0]=3, SETTLE_EDGES=2 -> Grant=0001 next cycle, DivResetVal=3, one-cycle DivReset pulse. Ready rises after the 2nd DivOutClock toggle; check the exact cycle against a divider model.
2. Req=1111 held in IDLE with pointer 0; each owner drops Req one cycle after its Ready -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
3. Owner 2 drops Req during SETTLE (after 1 toggle) -> Grant=0, Ready never asserts; pointer=3, so a pending Req[1|3] grants 3 first.
4. In OWNED with ratio 5, change ReqRatio[owner] to 9 -> DivResetVal stays 5, no DivReset pulse, Ready stays 1.
5. ResetN pulsed low during SETTLE -> Grant=0, Ready=0, DivReset=1 immediately (asynchronous). After release, a re-request re-runs the full LOAD/SETTLE.
6. Ratio 0, SETTLE_EDGES=1 -> DivOutClock toggles every cycle; Ready asserts 4 cycles after Req.

Source files
------------

// File: rtl/div_clock_arbiter.sv
// rtl/div_clock_arbiter.sv - round-robin arbiter sharing one variable clock divider
// Grants one requester, reloads the divider with its ratio and waits for the output to settle.
module div_clock_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BW_COUNT     = 5,
  parameter int SETTLE_EDGES = 2
) (
  input  logic                         Clock,
  input  logic                         ResetN,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*BW_COUNT-1:0]  ReqRatio,
  output logic [NUM_REQ-1:0]           Grant,
  output logic                         Ready,
  output logic [BW_COUNT-1:0]          DivResetVal,
  output logic                         DivReset,
  input  logic                         DivOutClock
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_OWNED  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                ready_q, ready_d;
  logic                div_reset_q, div_reset_d;
  logic [BW_COUNT-1:0] div_reset_val_q, div_reset_val_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                hist_q, hist_d;

  logic          found;
  logic [PW-1:0] sel;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && Req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    ready_d         = ready_q;
    div_reset_d     = 1'b0;
    div_reset_val_d = div_reset_val_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    hist_d          = hist_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d         = '0;
          grant_d[sel]    = 1'b1;
          owner_d         = sel;
          div_reset_val_d = ReqRatio[sel*BW_COUNT +: BW_COUNT];
          div_reset_d     = 1'b1;
          state_d         = ST_LOAD;
        end
      end
      ST_LOAD: begin
        hist_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE, ST_OWNED: begin
        if (!Req[owner_q]) begin
          grant_d = '0;
          ready_d = 1'b0;
          state_d = ST_IDLE;
          ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (state_q == ST_SETTLE) begin
          hist_d = DivOutClock;
          if (DivOutClock != hist_q) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(SETTLE_EDGES)) begin
            ready_d = 1'b1;
            state_d = ST_OWNED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      ready_q         <= 1'b0;
      div_reset_q     <= 1'b1;
      div_reset_val_q <= '0;
      ptr_q           <= '0;
      owner_q         <= '0;
      cnt_q           <= '0;
      hist_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      ready_q         <= ready_d;
      div_reset_q     <= div_reset_d;
      div_reset_val_q <= div_reset_val_d;
      ptr_q           <= ptr_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      hist_q          <= hist_d;
    end
  end

  assign Grant       = grant_q;
  assign Ready       = ready_q;
  assign DivReset    = div_reset_q;
  assign DivResetVal = div_reset_val_q;

endmodule
